// File: rtl/mem_rsp_pipe_if.sv
// Request/response bundle between a memory initiator (cache fill logic) and mem_rsp_pipe.
// Handshake: the responder is always ready, so a request transfers on every rising edge
// where enable=1; a response is present for exactly the cycles where data_valid=1.
interface mem_rsp_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] addr_out;
  logic [3:0]        pending;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, addr_out, pending
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, addr_out, pending
  );
endinterface

// File: rtl/mem_rsp_pipe.sv
// Fully pipelined main-memory model: one request per cycle, reads return in order
// exactly LATENCY cycles after acceptance with the echoed request address.
module mem_rsp_pipe #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 15,
  parameter int LATENCY = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_rsp_pipe_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] idx;
  logic               rd_accept;
  logic               wr_accept;
  logic [DATA_W-1:0]  rd_word;
  logic [ADDR_W-1:0]  rd_addr;

  logic [LATENCY-1:0] stg_valid;
  logic [DATA_W-1:0]  stg_data [LATENCY];
  logic [ADDR_W-1:0]  stg_addr [LATENCY];
  logic [3:0]         pend_q;

  // Bit 0 is the byte lane; bits above DEPTH_W alias onto the same words.
  assign idx = bus.addr[DEPTH_W:1];

  // enable gates everything, so X on wr/addr while idle never reaches state.
  always_comb begin
    rd_accept = 1'b0;
    wr_accept = 1'b0;
    rd_word   = '0;
    rd_addr   = '0;
    if (bus.enable) begin
      rd_accept = ~bus.wr;
      wr_accept = bus.wr;
    end
    if (rd_accept) begin
      rd_word = mem[idx];
      rd_addr = bus.addr;
    end
  end

  // Array contents survive reset; only requests seen during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      mem[idx] <= bus.data_in;
    end
  end

  // Bubbles carry zero data/address so the output stage needs no gating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_data[i] <= '0;
        stg_addr[i] <= '0;
      end
    end else begin
      stg_valid[0] <= rd_accept;
      stg_data[0]  <= rd_word;
      stg_addr[0]  <= rd_addr;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_data[i]  <= stg_data[i-1];
        stg_addr[i]  <= stg_addr[i-1];
      end
    end
  end

  // A word counts as pending through its data_valid cycle and leaves on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      case ({rd_accept, stg_valid[LATENCY-1]})
        2'b10:   pend_q <= pend_q + 4'd1;
        2'b01:   pend_q <= pend_q - 4'd1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign bus.data_valid = stg_valid[LATENCY-1];
  assign bus.data_out   = stg_data[LATENCY-1];
  assign bus.addr_out   = stg_addr[LATENCY-1];
  assign bus.pending    = pend_q;

endmodule

// File: tb/tb_mem_rsp_pipe.sv
// Directed bench for mem_rsp_pipe: LATENCY 4 (scoreboard + pending), LATENCY 1 with a small
// aliased array, and LATENCY 8 over an alternating read/idle window.
module tb_mem_rsp_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          win8 = 1'b0;

  exp_t        exp_q[$];
  logic [15:0] mem_big[int];
  logic [15:0] mem_small[int];
  logic [15:0] rd1_data[int];
  logic [15:0] rd1_addr[int];
  logic [15:0] rd8_data[int];
  logic [15:0] rd8_addr[int];

  mem_rsp_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus4 ();
  mem_rsp_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  mem_rsp_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus8 ();

  assign bus4.enable = enable;
  assign bus4.wr = wr;
  assign bus4.addr = addr;
  assign bus4.data_in = data_in;
  assign bus1.enable = enable;
  assign bus1.wr = wr;
  assign bus1.addr = addr;
  assign bus1.data_in = data_in;
  assign bus8.enable = enable;
  assign bus8.wr = wr;
  assign bus8.addr = addr;
  assign bus8.data_in = data_in;

  mem_rsp_pipe #(.LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mem_rsp_pipe #(.DEPTH_W(10), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_rsp_pipe #(.LATENCY(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // driver: inputs change 1 time unit after the falling edge, after the monitor has sampled
  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    #1;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    if (en === 1'b1 && w === 1'b1) begin
      mem_big[int'(a[15:1])]  = d;
      mem_small[int'(a[10:1])] = d;
    end
    if (en === 1'b1 && w === 1'b0) begin
      exp_q.push_back('{data: mem_big[int'(a[15:1])], addr: a, acc: 32'(cyc + 1)});
      rd1_data[cyc + 1] = mem_small[int'(a[10:1])];
      rd1_addr[cyc + 1] = a;
      rd8_data[cyc + 8] = mem_big[int'(a[15:1])];
      rd8_addr[cyc + 8] = a;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'bx, 16'hxxxx, 16'hxxxx);
  endtask

  // reset with a write presented during it, which must be ignored
  task automatic apply_reset(input int n);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = 16'h0010;
    data_in = 16'hDEAD;
    exp_q.delete();
    rd1_data.delete();
    rd1_addr.delete();
    rd8_data.delete();
    rd8_addr.delete();
    repeat (n) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b0;
  endtask

  // scoreboard / monitors
  always @(negedge clk) begin : mon
    exp_t e;
    bit   due;
    check("lat4_pending", 32'(bus4.pending), 32'(exp_q.size()));
    if (bus4.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("lat4_unexpected_valid", 32'(bus4.data_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("lat4_data", 32'(bus4.data_out), 32'(e.data));
        check("lat4_addr", 32'(bus4.addr_out), 32'(e.addr));
        check("lat4_due_cycle", 32'(cyc), e.acc + 32'd3);
      end
    end else begin
      check("lat4_idle_valid", 32'(bus4.data_valid), 32'd0);
      check("lat4_idle_data", 32'(bus4.data_out), 32'd0);
      check("lat4_idle_addr", 32'(bus4.addr_out), 32'd0);
      if (exp_q.size() > 0 && int'(exp_q[0].acc) + 3 <= cyc) begin
        check("lat4_missing_valid", 32'(bus4.data_valid), 32'd1);
        e = exp_q.pop_front();
      end
    end

    due = rd1_data.exists(cyc);
    check("lat1_valid", 32'(bus1.data_valid), 32'(due));
    if (due) begin
      check("lat1_data", 32'(bus1.data_out), 32'(rd1_data[cyc]));
      check("lat1_addr", 32'(bus1.addr_out), 32'(rd1_addr[cyc]));
    end else begin
      check("lat1_idle_data", 32'(bus1.data_out), 32'd0);
    end

    if (win8) begin
      due = rd8_data.exists(cyc);
      check("lat8_valid", 32'(bus8.data_valid), 32'(due));
      if (due) begin
        check("lat8_data", 32'(bus8.data_out), 32'(rd8_data[cyc]));
        check("lat8_addr", 32'(bus8.addr_out), 32'(rd8_addr[cyc]));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // single write then read, pending 1 while in flight
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(6);

    // 8 writes, 8 back-to-back reads; pending saturates at 4
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'h0020 + 16'(2 * i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'h0020 + 16'(2 * i), 16'h0000);
    idle(6);

    // snapshot: write after read does not change that read
    drive(1'b1, 1'b1, 16'h0030, 16'h1111);
    drive(1'b1, 1'b0, 16'h0030, 16'h0000);
    drive(1'b1, 1'b1, 16'h0030, 16'h2222);
    drive(1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(6);

    // reset mid-burst discards in-flight reads, array survives
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    drive(1'b1, 1'b0, 16'h0022, 16'h0000);
    drive(1'b1, 1'b0, 16'h0024, 16'h0000);
    apply_reset(1);
    idle(2);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(10);

    // aliasing: 0x0802 aliases word 1 only in the DEPTH_W=10 instance
    drive(1'b1, 1'b1, 16'h0802, 16'h5A5A);
    drive(1'b1, 1'b1, 16'h0002, 16'hA5A5);
    drive(1'b1, 1'b0, 16'h0802, 16'h0000);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    idle(12);

    // alternating read/idle, checked on all three latencies
    win8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b0, 16'h0020 + 16'(4 * ((i / 2) % 4)), 16'h0000);
      else idle(1);
    end
    idle(10);
    win8 = 1'b0;

    check("lat4_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
